mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the shared memory port.
// The arbiter takes the master modport (it masters the memory); requesters and memory use slave.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_valid;
  logic        dm_err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, if_err, dm_rdata, dm_valid, dm_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, if_err, dm_rdata, dm_valid, dm_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data port has priority, fetch is served after
// STARVE_MAX consecutive data grants; accesses abort after TIMEOUT wait cycles.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int unsigned SW = 4;
  localparam int unsigned WW = 8;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM, DONE} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_starve_cnt;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_mem_en;
  logic            r_mem_we;
  logic [DW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   r_if_rdata;
  logic [DW-1:0]   r_dm_rdata;
  logic            r_if_valid;
  logic            r_if_err;
  logic            r_dm_valid;
  logic            r_dm_err;
  logic            w_grant_if;

  // Fetch wins only when data is absent or fetch has been starved long enough.
  assign w_grant_if = bus.if_req && (!bus.dm_req || (r_starve_cnt == SW'(STARVE_MAX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_if_valid   <= 1'b0;
      r_if_err     <= 1'b0;
      r_dm_valid   <= 1'b0;
      r_dm_err     <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_dm_valid <= 1'b0;
      r_dm_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_if) begin
            r_state      <= ACC_IF;
            r_mem_en     <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= bus.if_addr;
            r_mem_wdata  <= '0;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
          end else if (bus.dm_req) begin
            r_state     <= ACC_DM;
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.dm_we;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
            r_wait_cnt  <= '0;
            // Counter stays below STARVE_MAX here, so this saturates naturally.
            if (bus.if_req) r_starve_cnt <= r_starve_cnt + SW'(1);
          end
        end
        ACC_IF, ACC_DM: begin
          if (bus.mem_ready) begin
            r_state  <= DONE;
            r_mem_en <= 1'b0;
            if (r_state == ACC_IF) begin
              r_if_valid <= 1'b1;
              r_if_rdata <= bus.mem_rdata;
            end else begin
              r_dm_valid <= 1'b1;
              if (!r_mem_we) r_dm_rdata <= bus.mem_rdata;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
            if (r_wait_cnt == WW'(TIMEOUT - 1)) begin
              r_state  <= DONE;
              r_mem_en <= 1'b0;
              if (r_state == ACC_IF) r_if_err <= 1'b1;
              else                   r_dm_err <= 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_err    = r_if_err;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.dm_valid  = r_dm_valid;
  assign bus.dm_err    = r_dm_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, latency and read data.
module tb_mem_arbiter;
  localparam int SM = 3;
  localparam int TO = 15;

  logic clk;
  logic rst;
  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int m_starve;
  logic [15:0] m_if_rdata;
  logic [15:0] m_dm_rdata;
  bit grant_log[$];

  function automatic logic [3:0] pulses();
    return {bus.if_valid, bus.if_err, bus.dm_valid, bus.dm_err};
  endfunction

  // One complete access: predict the winner, act as memory with latency lat
  // (lat > TO means never ready), then check pulses, length and read data.
  task automatic access(input int lat, input logic [15:0] word, input bit keep);
    bit g_if, seen, ok, stable;
    logic e_we;
    logic [15:0] e_addr, e_wdata;
    logic [3:0] e_p;
    int waited, len, e_len;
    if (!bus.if_req && !bus.dm_req) return;
    g_if    = bus.if_req && !(bus.dm_req && m_starve < SM);
    e_addr  = g_if ? bus.if_addr : bus.dm_addr;
    e_we    = g_if ? 1'b0 : bus.dm_we;
    e_wdata = bus.dm_wdata;
    if (g_if) m_starve = 0;
    else if (bus.if_req) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
    seen = 0; waited = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      waited++;
      if (bus.mem_en === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen || waited != 1) begin
      n_fail++;
      $display("FAIL grant_latency: got %0d cycles (seen=%0d) want 1", waited, seen);
    end
    if (!seen) return;
    grant_log.push_back(g_if);
    n_checks++;
    if (bus.mem_addr !== e_addr || bus.mem_we !== e_we || (e_we && bus.mem_wdata !== e_wdata)) begin
      n_fail++;
      $display("FAIL grant_fields: got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
               bus.mem_addr, bus.mem_we, bus.mem_wdata, e_addr, e_we, e_wdata);
    end
    if (g_if) bus.if_addr = 16'($urandom);
    else begin
      bus.dm_addr  = 16'($urandom);
      bus.dm_wdata = 16'($urandom);
      bus.dm_we    = 1'($urandom);
    end
    len = 0; stable = 1;
    while (len < 300) begin
      len++;
      bus.mem_ready = (len == lat);
      bus.mem_rdata = (len == lat) ? word : 16'($urandom);
      @(negedge clk);
      if (bus.mem_en !== 1'b1) break;
      if (bus.mem_addr !== e_addr || bus.mem_we !== e_we || pulses() !== 4'b0) stable = 0;
    end
    bus.mem_ready = 1'b0;
    ok    = (lat <= TO);
    e_len = ok ? lat : TO;
    e_p   = {g_if && ok, g_if && !ok, !g_if && ok, !g_if && !ok};
    if (ok && g_if) m_if_rdata = word;
    if (ok && !g_if && !e_we) m_dm_rdata = word;
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL access_stable: got unstable mem bus want stable");
    end
    n_checks++;
    if (len != e_len) begin
      n_fail++;
      $display("FAIL access_len: got %0d want %0d", len, e_len);
    end
    n_checks++;
    if (pulses() !== e_p) begin
      n_fail++;
      $display("FAIL completion_pulses: got %b want %b", pulses(), e_p);
    end
    n_checks++;
    if (bus.if_rdata !== m_if_rdata || bus.dm_rdata !== m_dm_rdata) begin
      n_fail++;
      $display("FAIL rdata: got if=%h dm=%h want if=%h dm=%h",
               bus.if_rdata, bus.dm_rdata, m_if_rdata, m_dm_rdata);
    end
    if (keep) begin
      if (g_if) bus.if_addr = 16'($urandom);
      else begin
        bus.dm_addr  = 16'($urandom);
        bus.dm_wdata = 16'($urandom);
        bus.dm_we    = 1'($urandom);
      end
    end else if (g_if) bus.if_req = 1'b0;
    else bus.dm_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pulses() !== 4'b0 || bus.mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL turnaround: got pulses=%b mem_en=%b want 0000 0", pulses(), bus.mem_en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata, pulses()} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h wd=%h ifr=%h dmr=%h p=%b want all 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata, pulses());
    end
    rst = 1'b0;
    m_starve = 0; m_if_rdata = '0; m_dm_rdata = '0;
  endtask

  task automatic test_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0040;
    access(1, 16'h1234, 1'b0);
    n_checks++;
    if (bus.if_rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h want 1234", bus.if_rdata);
    end
  endtask

  task automatic test_both();
    int base;
    base = grant_log.size();
    bus.if_req   = 1'b1; bus.if_addr  = 16'($urandom);
    bus.dm_req   = 1'b1; bus.dm_we    = 1'b1;
    bus.dm_addr  = 16'h8000; bus.dm_wdata = 16'hBEEF;
    access(1, 16'($urandom), 1'b0);
    access(1, 16'($urandom), 1'b0);
    n_checks++;
    if (grant_log.size() != base + 2 || grant_log[base] != 1'b0 || grant_log[base+1] != 1'b1) begin
      n_fail++;
      $display("FAIL store_then_fetch: got %0d grants want data then fetch", grant_log.size() - base);
    end
  endtask

  task automatic test_starve();
    bit ok;
    grant_log.delete();
    bus.if_req = 1'b1; bus.if_addr = 16'($urandom);
    bus.dm_req = 1'b1; bus.dm_we = 1'($urandom);
    bus.dm_addr = 16'($urandom); bus.dm_wdata = 16'($urandom);
    for (int i = 0; i < 8; i++) access($urandom_range(1, 3), 16'($urandom), i != 7);
    bus.dm_req = 1'b0;
    ok = (grant_log.size() == 8);
    for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] != (i % 4 == 3)) ok = 0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL starve_pattern: got %0d grants with wrong order want D,D,D,F x2", grant_log.size());
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.mem_en !== 1'b0 || pulses() !== 4'b0) begin
      n_fail++;
      $display("FAIL dropped_request: got mem_en=%b p=%b want 0 0000", bus.mem_en, pulses());
    end
  endtask

  task automatic test_timeout();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'($urandom);
    access(100, 16'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'($urandom);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) seen = 1;
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (!seen || bus.mem_en !== 1'b0 || pulses() !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid_access: got seen=%0d mem_en=%b p=%b want 1 0 0000", seen, bus.mem_en, pulses());
    end
    bus.dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_starve = 0; m_if_rdata = '0; m_dm_rdata = '0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_en !== 1'b0 || pulses() !== 4'b0 || bus.dm_rdata !== 16'h0) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got activity after reset want none");
    end
    bus.if_req = 1'b1; bus.if_addr = 16'($urandom);
    access(2, 16'($urandom), 1'b0);
  endtask

  task automatic test_idle_ready();
    bit bad;
    bad = 0;
    bus.mem_ready = 1'b1;
    repeat (6) begin
      bus.mem_rdata = 16'($urandom);
      @(negedge clk);
      if (bus.mem_en !== 1'b0 || pulses() !== 4'b0 ||
          bus.if_rdata !== m_if_rdata || bus.dm_rdata !== m_dm_rdata) bad = 1;
    end
    bus.mem_ready = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL idle_ready: got output change want none");
    end
  endtask

  task automatic test_random();
    int mode;
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 3);
      bus.if_req   = mode[0];
      bus.dm_req   = mode[1];
      bus.if_addr  = 16'($urandom);
      bus.dm_addr  = 16'($urandom);
      bus.dm_wdata = 16'($urandom);
      bus.dm_we    = 1'($urandom);
      if (mode == 0) @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (bus.if_req || bus.dm_req) access($urandom_range(1, 18), 16'($urandom), 1'b0);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    n_checks = 0; n_fail = 0;
    m_starve = 0; m_if_rdata = '0; m_dm_rdata = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_both();
    test_starve();
    test_timeout();
    test_reset_mid();
    test_idle_ready();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
